// File: rtl/sprite_engine.sv
// Multi-sprite generator for the VGA pixel mux.
//
// Sprite attributes, 2-bpp pattern rows and four 4-entry palettes are written at run time.
// During hblank a scanner picks up to MAX_PER_LINE sprites for the next line and preloads
// their pattern rows. During active video the highest-priority opaque pixel is output,
// registered, one clk after hcount/vcount.
//
// Ports:
//   clk, reset     50 MHz clock, asynchronous active-high reset
//   hcount/vcount  VGA counters; pixel x = hcount[10:1], lines 0..524
//   attr_we/idx/data   attribute write {en, pal[1:0], pat[7:0], y[9:0], x[9:0]}
//   pat_we/addr/data   pattern row write, addr = {pattern, row}
//   pal_we/addr/data   palette write, addr = {pal[1:0], index[1:0]}, RGB888
//   sprite_color/valid winning pixel colour and opaque flag
//   line_overflow  one-cycle pulse when a scanned line has too many sprites
//   collision      sticky per frame; two opaque sprite pixels overlapped
module sprite_engine #(
    parameter int unsigned NUM_SPRITES  = 8,
    parameter int unsigned MAX_PER_LINE = 4,
    parameter int unsigned SPRITE_SIZE  = 16,
    parameter int unsigned NUM_PATTERNS = 64,
    parameter int unsigned HACTIVE      = 640,
    parameter int unsigned VACTIVE      = 480
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [10:0]                                          hcount,
    input  logic [9:0]                                           vcount,
    input  logic                                                 attr_we,
    input  logic [$clog2(NUM_SPRITES)-1:0]                       attr_idx,
    input  logic [30:0]                                          attr_data,
    input  logic                                                 pat_we,
    input  logic [$clog2(NUM_PATTERNS)+$clog2(SPRITE_SIZE)-1:0]  pat_addr,
    input  logic [2*SPRITE_SIZE-1:0]                             pat_data,
    input  logic                                                 pal_we,
    input  logic [3:0]                                           pal_addr,
    input  logic [23:0]                                          pal_data,
    output logic [23:0]                                          sprite_color,
    output logic                                                 sprite_valid,
    output logic                                                 line_overflow,
    output logic                                                 collision
);

    localparam int unsigned IdxW     = $clog2(NUM_SPRITES);
    localparam int unsigned PatW     = $clog2(NUM_PATTERNS);
    localparam int unsigned RowW     = $clog2(SPRITE_SIZE);
    localparam int unsigned RowBits  = 2 * SPRITE_SIZE;
    localparam int unsigned SlotW    = $clog2(MAX_PER_LINE + 1);
    localparam int unsigned SlotIdxW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int unsigned VLast    = 524;

    typedef enum logic [1:0] {StIdle, StScan, StFetch, StReady} state_e;

    // ------------------------------------------------------------------
    // Attribute table, pattern RAM, palette RAM
    // ------------------------------------------------------------------
    logic            attr_en_q  [NUM_SPRITES];
    logic [1:0]      attr_pal_q [NUM_SPRITES];
    logic [PatW-1:0] attr_pat_q [NUM_SPRITES];
    logic [9:0]      attr_y_q   [NUM_SPRITES];
    logic [9:0]      attr_x_q   [NUM_SPRITES];

    logic [RowBits-1:0] pat_mem [NUM_PATTERNS*SPRITE_SIZE];
    logic [23:0]        pal_mem [16];

    // Pattern field is 8 bits wide; only the low PatW bits address the RAM.
    logic unused_attr_pat;
    assign unused_attr_pat = ^attr_data[27:20];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) attr_en_q[i] <= 1'b0;
        end else if (attr_we) begin
            attr_en_q[attr_idx] <= attr_data[30];
        end
    end

    always_ff @(posedge clk) begin
        if (attr_we) begin
            attr_pal_q[attr_idx] <= attr_data[29:28];
            attr_pat_q[attr_idx] <= attr_data[20 +: PatW];
            attr_y_q[attr_idx]   <= attr_data[19:10];
            attr_x_q[attr_idx]   <= attr_data[9:0];
        end
        if (pat_we) pat_mem[pat_addr] <= pat_data;
        if (pal_we) pal_mem[pal_addr] <= pal_data;
    end

    // ------------------------------------------------------------------
    // Scanner FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [9:0]      line_q, line_d;
    logic [IdxW-1:0] scan_idx_q, scan_idx_d;
    logic [SlotW-1:0] cnt_q, cnt_d;
    logic [SlotW-1:0] fetch_idx_q, fetch_idx_d;
    logic            ovf_seen_q, ovf_seen_d;

    logic       slot_load, fetch_load, disp_load, ovf_pulse;
    logic [9:0] next_line;
    logic [10:0] scan_diff;
    logic       scan_hit;

    assign next_line = (vcount == 10'(VLast)) ? 10'd0 : vcount + 10'd1;
    assign scan_diff = {1'b0, line_q} - {1'b0, attr_y_q[scan_idx_q]};
    assign scan_hit  = attr_en_q[scan_idx_q] && !scan_diff[10]
                       && (scan_diff < 11'(SPRITE_SIZE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            line_q      <= '0;
            scan_idx_q  <= '0;
            cnt_q       <= '0;
            fetch_idx_q <= '0;
            ovf_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            scan_idx_q  <= scan_idx_d;
            cnt_q       <= cnt_d;
            fetch_idx_q <= fetch_idx_d;
            ovf_seen_q  <= ovf_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        scan_idx_d  = scan_idx_q;
        cnt_d       = cnt_q;
        fetch_idx_d = fetch_idx_q;
        ovf_seen_d  = ovf_seen_q;
        slot_load   = 1'b0;
        fetch_load  = 1'b0;
        disp_load   = 1'b0;
        ovf_pulse   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hcount == 11'(2 * HACTIVE)) begin
                    line_d      = next_line;
                    scan_idx_d  = '0;
                    cnt_d       = '0;
                    fetch_idx_d = '0;
                    ovf_seen_d  = 1'b0;
                    // Lines in vertical blank get an empty slot set.
                    state_d     = (next_line >= 10'(VACTIVE)) ? StReady : StScan;
                end
            end
            StScan: begin
                if (scan_hit) begin
                    if (cnt_q < SlotW'(MAX_PER_LINE)) begin
                        slot_load = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                    end else if (!ovf_seen_q) begin
                        ovf_pulse  = 1'b1;
                        ovf_seen_d = 1'b1;
                    end
                end
                scan_idx_d = scan_idx_q + 1'b1;
                if (scan_idx_q == IdxW'(NUM_SPRITES - 1)) state_d = StFetch;
            end
            StFetch: begin
                if (cnt_q == '0) begin
                    state_d = StReady;
                end else begin
                    fetch_load  = 1'b1;
                    fetch_idx_d = fetch_idx_q + 1'b1;
                    if (fetch_idx_q + 1'b1 == cnt_q) state_d = StReady;
                end
            end
            StReady: begin
                if (hcount == 11'd0) begin
                    disp_load = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Staging (filled in hblank) and display slots (used in active video)
    // ------------------------------------------------------------------
    logic [9:0]         stage_x_q    [MAX_PER_LINE];
    logic [1:0]         stage_pal_q  [MAX_PER_LINE];
    logic [PatW-1:0]    stage_pat_q  [MAX_PER_LINE];
    logic [RowW-1:0]    stage_row_q  [MAX_PER_LINE];
    logic [RowBits-1:0] stage_bits_q [MAX_PER_LINE];

    logic               disp_valid_q [MAX_PER_LINE];
    logic [9:0]         disp_x_q     [MAX_PER_LINE];
    logic [1:0]         disp_pal_q   [MAX_PER_LINE];
    logic [RowBits-1:0] disp_bits_q  [MAX_PER_LINE];

    logic [SlotIdxW-1:0] load_slot, fetch_slot;
    assign load_slot  = cnt_q[SlotIdxW-1:0];
    assign fetch_slot = fetch_idx_q[SlotIdxW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                stage_x_q[i]    <= '0;
                stage_pal_q[i]  <= '0;
                stage_pat_q[i]  <= '0;
                stage_row_q[i]  <= '0;
                stage_bits_q[i] <= '0;
                disp_valid_q[i] <= 1'b0;
                disp_x_q[i]     <= '0;
                disp_pal_q[i]   <= '0;
                disp_bits_q[i]  <= '0;
            end
        end else begin
            if (slot_load) begin
                stage_x_q[load_slot]   <= attr_x_q[scan_idx_q];
                stage_pal_q[load_slot] <= attr_pal_q[scan_idx_q];
                stage_pat_q[load_slot] <= attr_pat_q[scan_idx_q];
                stage_row_q[load_slot] <= scan_diff[RowW-1:0];
            end
            if (fetch_load) begin
                stage_bits_q[fetch_slot] <=
                    pat_mem[{stage_pat_q[fetch_slot], stage_row_q[fetch_slot]}];
            end
            if (disp_load) begin
                for (int i = 0; i < MAX_PER_LINE; i++) begin
                    disp_valid_q[i] <= (SlotW'(i) < cnt_q);
                    disp_x_q[i]     <= stage_x_q[i];
                    disp_pal_q[i]   <= stage_pal_q[i];
                    disp_bits_q[i]  <= stage_bits_q[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel evaluation
    // ------------------------------------------------------------------
    // On the copy edge (hcount==0) the display slots still hold the previous line, so pixel 0
    // is evaluated from the staging registers directly.
    logic       use_stage;
    logic [9:0] px;
    logic       in_active;
    assign use_stage = (state_q == StReady) && (hcount == 11'd0);
    assign px        = hcount[10:1];
    assign in_active = (hcount < 11'(2 * HACTIVE)) && (vcount < 10'(VACTIVE));

    logic [MAX_PER_LINE-1:0] slot_opaque;
    logic [1:0]              slot_pix [MAX_PER_LINE];
    logic [1:0]              slot_pal [MAX_PER_LINE];

    for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_slot
        logic               v;
        logic [9:0]         sx;
        logic [RowBits-1:0] sbits;
        logic [10:0]        c;
        logic [RowW-1:0]    col;
        logic [RowBits-1:0] sh;

        assign v     = use_stage ? (SlotW'(g) < cnt_q) : disp_valid_q[g];
        assign sx    = use_stage ? stage_x_q[g] : disp_x_q[g];
        assign sbits = use_stage ? stage_bits_q[g] : disp_bits_q[g];
        assign c     = {1'b0, px} - {1'b0, sx};
        // Pixel 0 sits in the top bit pair of the row.
        assign col   = RowW'(SPRITE_SIZE - 1) - c[RowW-1:0];
        assign sh    = sbits >> {col, 1'b0};

        assign slot_pix[g]    = sh[1:0];
        assign slot_pal[g]    = use_stage ? stage_pal_q[g] : disp_pal_q[g];
        assign slot_opaque[g] = v && !c[10] && (c < 11'(SPRITE_SIZE)) && (sh[1:0] != 2'b00);
    end

    logic       win_found, overlap;
    logic [1:0] win_pal, win_pix;

    always_comb begin
        win_found = 1'b0;
        overlap   = 1'b0;
        win_pal   = '0;
        win_pix   = '0;
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (slot_opaque[i]) begin
                if (win_found) begin
                    overlap = 1'b1;
                end else begin
                    win_found = 1'b1;
                    win_pal   = slot_pal[i];
                    win_pix   = slot_pix[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [23:0] color_q;
    logic        valid_q, ovf_q, coll_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            color_q <= (in_active && win_found) ? pal_mem[{win_pal, win_pix}] : 24'd0;
            valid_q <= in_active && win_found;
            ovf_q   <= ovf_pulse;
            // Set wins over the frame-start clear.
            if (in_active && overlap)             coll_q <= 1'b1;
            else if (vcount == '0 && hcount == '0) coll_q <= 1'b0;
        end
    end

    assign sprite_color  = color_q;
    assign sprite_valid  = valid_q;
    assign line_overflow = ovf_q;
    assign collision     = coll_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: hcount/vcount are driven directly, running only the
// hblank window needed for the scan and then the pixels of interest.
module tb_sprite_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        attr_we;
    logic [2:0]  attr_idx;
    logic [30:0] attr_data;
    logic        pat_we;
    logic [9:0]  pat_addr;
    logic [31:0] pat_data;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;
    logic [23:0] sprite_color;
    logic        sprite_valid;
    logic        line_overflow;
    logic        collision;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_engine dut (
        .clk          (clk),
        .reset        (reset),
        .hcount       (hcount),
        .vcount       (vcount),
        .attr_we      (attr_we),
        .attr_idx     (attr_idx),
        .attr_data    (attr_data),
        .pat_we       (pat_we),
        .pat_addr     (pat_addr),
        .pat_data     (pat_data),
        .pal_we       (pal_we),
        .pal_addr     (pal_addr),
        .pal_data     (pal_data),
        .sprite_color (sprite_color),
        .sprite_valid (sprite_valid),
        .line_overflow(line_overflow),
        .collision    (collision)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_attr(input int idx, input bit en, input int pal, input int pat,
                              input int y, input int x);
        attr_idx  = 3'(idx);
        attr_data = {en, 2'(pal), 8'(pat), 10'(y), 10'(x)};
        attr_we   = 1'b1;
        tick();
        attr_we   = 1'b0;
    endtask

    // Run the hblank of the line before v, then the hcount==0 copy edge of line v.
    task automatic prep(input int v, output int ovf);
        ovf    = 0;
        vcount = (v == 0) ? 10'd524 : 10'(v - 1);
        for (int h = 1280; h <= 1310; h++) begin
            hcount = 11'(h);
            tick();
            if (line_overflow) ovf++;
        end
        vcount = 10'(v);
        hcount = 11'd0;
        tick();
    endtask

    task automatic pix(input string tag, input int v, input int px, input logic [23:0] exp);
        vcount = 10'(v);
        hcount = 11'(2 * px);
        tick();
        check_eq({tag, ".valid"}, 32'(sprite_valid), 32'(exp != 24'd0));
        check_eq({tag, ".color"}, 32'(sprite_color), 32'(exp));
    endtask

    initial begin
        int ovf;
        reset = 1'b1; hcount = 11'd1500; vcount = 10'd500;
        attr_we = 0; attr_idx = 0; attr_data = 0;
        pat_we = 0; pat_addr = 0; pat_data = 0;
        pal_we = 0; pal_addr = 0; pal_data = 0;
        tick(); tick();
        check_eq("rst.valid", 32'(sprite_valid), 32'd0);
        check_eq("rst.color", 32'(sprite_color), 32'd0);
        check_eq("rst.ovf", 32'(line_overflow), 32'd0);
        check_eq("rst.coll", 32'(collision), 32'd0);
        reset = 1'b0;

        // Pattern 0: all index 1, 1: all index 2, 2: left half clear, right half index 3.
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 16; r++) begin
                pat_addr = 10'(p * 16 + r);
                pat_data = (p == 0) ? 32'h5555_5555 : (p == 1) ? 32'hAAAA_AAAA : 32'h0000_FFFF;
                pat_we   = 1'b1;
                tick();
            end
        end
        pat_we = 1'b0;
        pal_we = 1'b1;
        pal_addr = 4'h1; pal_data = 24'hFF0000; tick();
        pal_addr = 4'h2; pal_data = 24'h00FF00; tick();
        pal_addr = 4'h3; pal_data = 24'h0000FF; tick();
        pal_addr = 4'h5; pal_data = 24'h111111; tick();
        pal_addr = 4'h9; pal_data = 24'h222222; tick();
        pal_addr = 4'hD; pal_data = 24'h333333; tick();
        pal_we = 1'b0;

        // Single sprite at (100, 50).
        write_attr(0, 1, 0, 0, 50, 100);
        prep(49, ovf);
        pix("l49.px100", 49, 100, 24'h0);
        prep(50, ovf);
        check_eq("l50.ovf", 32'(ovf), 32'd0);
        pix("l50.px99", 50, 99, 24'h0);
        pix("l50.px100", 50, 100, 24'hFF0000);
        pix("l50.px115", 50, 115, 24'hFF0000);
        pix("l50.px116", 50, 116, 24'h0);
        prep(65, ovf);
        pix("l65.px100", 65, 100, 24'hFF0000);
        prep(66, ovf);
        pix("l66.px100", 66, 100, 24'h0);

        // Sprites 0 and 3 fully overlapping: sprite 0 wins, collision is sticky.
        write_attr(3, 1, 0, 1, 50, 100);
        prep(50, ovf);
        pix("ovl.px99", 50, 99, 24'h0);
        check_eq("ovl.coll_before", 32'(collision), 32'd0);
        pix("ovl.px100", 50, 100, 24'hFF0000);
        check_eq("ovl.coll_first", 32'(collision), 32'd1);
        pix("ovl.px120", 50, 120, 24'h0);
        check_eq("ovl.coll_sticky", 32'(collision), 32'd1);
        vcount = 10'd0; hcount = 11'd0; tick();
        check_eq("ovl.coll_clear", 32'(collision), 32'd0);

        // Sprite 0 transparent on its left half: sprite 3 shows through there.
        write_attr(0, 1, 0, 2, 50, 100);
        prep(50, ovf);
        pix("half.px107", 50, 107, 24'h00FF00);
        check_eq("half.coll_none", 32'(collision), 32'd0);
        pix("half.px108", 50, 108, 24'h0000FF);
        check_eq("half.coll_set", 32'(collision), 32'd1);
        vcount = 10'd0; hcount = 11'd0; tick();

        // Six sprites on line 200: only 0..3 shown, one overflow pulse.
        for (int i = 0; i < 6; i++) write_attr(i, 1, i % 4, 0, 200, 300 + 20 * i);
        prep(200, ovf);
        check_eq("six.ovf_pulses", 32'(ovf), 32'd1);
        pix("six.s0", 200, 300, 24'hFF0000);
        pix("six.s1", 200, 320, 24'h111111);
        pix("six.s2", 200, 340, 24'h222222);
        pix("six.s3", 200, 360, 24'h333333);
        pix("six.s4", 200, 380, 24'h0);
        pix("six.s5", 200, 400, 24'h0);
        for (int i = 1; i < 6; i++) write_attr(i, 0, 0, 0, 0, 0);

        // Clipping at the right and bottom edges, no wrap.
        write_attr(0, 1, 0, 0, 470, 632);
        prep(470, ovf);
        pix("clip.px631", 470, 631, 24'h0);
        pix("clip.px632", 470, 632, 24'hFF0000);
        pix("clip.px639", 470, 639, 24'hFF0000);
        pix("clip.px641", 470, 641, 24'h0);
        pix("clip.px0", 470, 0, 24'h0);
        prep(479, ovf);
        pix("clip.l479", 479, 639, 24'hFF0000);
        prep(480, ovf);
        pix("clip.l480", 480, 632, 24'h0);
        prep(0, ovf);
        pix("clip.l0.px0", 0, 0, 24'h0);
        pix("clip.l0.px632", 0, 632, 24'h0);

        // Mid-line disable on line 300.
        write_attr(0, 1, 0, 0, 300, 240);
        prep(300, ovf);
        pix("dis.before", 300, 250, 24'hFF0000);
        vcount = 10'd300; hcount = 11'd600;
        write_attr(0, 0, 0, 0, 300, 240);
        pix("dis.same_line", 300, 250, 24'hFF0000);
        prep(301, ovf);
        pix("dis.next_line", 301, 250, 24'h0);

        // Reset mid-line at hcount 500.
        write_attr(0, 1, 0, 0, 300, 240);
        prep(302, ovf);
        pix("mrst.before", 302, 250, 24'hFF0000);
        reset = 1'b1;
        #1;
        check_eq("mrst.valid", 32'(sprite_valid), 32'd0);
        check_eq("mrst.color", 32'(sprite_color), 32'd0);
        tick();
        reset = 1'b0;
        write_attr(0, 1, 0, 0, 300, 240);
        pix("mrst.same_line", 302, 250, 24'h0);
        prep(303, ovf);
        pix("mrst.next_line", 303, 250, 24'hFF0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
